// File: rtl/lighting_pkg.sv
// Shared definitions for the lighting controller: time-code constants,
// controller FSM states and the lamp thermometer decode.
package lighting_pkg;

  localparam int unsigned TC_W = 4;

  // One-hot time-of-day codes; all other non-zero patterns are rejected.
  localparam logic [TC_W-1:0] TC_OFF  = 4'b0000;
  localparam logic [TC_W-1:0] TC_DAY  = 4'b0001;
  localparam logic [TC_W-1:0] TC_DUSK = 4'b0010;
  localparam logic [TC_W-1:0] TC_EVE  = 4'b0100;
  localparam logic [TC_W-1:0] TC_MAN  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Thermometer decode, one lamp at a time: lamp idx is lit when idx < cnt.
  function automatic logic therm_bit(input int unsigned idx, input int unsigned cnt);
    return idx < cnt;
  endfunction

endpackage

// File: rtl/ramp_step.sv
// Up/down register that moves one unit toward a target on each step strobe.
// Ports: clk, rst_n; step_i strobe; target_i goal; value_o current value;
//        at_target_o high while value_o equals target_i.
module ramp_step #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] value_o,
  output logic         at_target_o
);

  logic [W-1:0] value_q;

  // Moving only toward the target means the value can neither overshoot nor wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (step_i) begin
      if (value_q < target_i) begin
        value_q <= value_q + W'(1);
      end else if (value_q > target_i) begin
        value_q <= value_q - W'(1);
      end
    end
  end

  assign value_o     = value_q;
  assign at_target_o = (value_q == target_i);

endmodule

// File: rtl/light_ramp_ctrl.sv
// Lighting controller: accepts a time-of-day command, derives shade and lamp
// targets, then ramps both one step every STEP_CYCLES clocks and pulses done.
// Ports: clk, rst_n; cmd_valid/cmd_ready handshake; tcode, ulight, length
//        command fields; wshade, lightnum, lightstate current lighting;
//        busy while ramping; done one-cycle completion; err invalid tcode.
module light_ramp_ctrl
  import lighting_pkg::*;
#(
  parameter  int unsigned NUM_LIGHTS  = 16,
  parameter  int unsigned LVL_W       = 4,
  parameter  int unsigned STEP_CYCLES = 4,
  parameter  int unsigned ULIGHT_TH   = 8,
  localparam int unsigned CNT_W       = $clog2(NUM_LIGHTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            tcode,
  input  logic [LVL_W-1:0]      ulight,
  input  logic [CNT_W-1:0]      length,
  output logic [LVL_W-1:0]      wshade,
  output logic [CNT_W-1:0]      lightnum,
  output logic [NUM_LIGHTS-1:0] lightstate,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned       PS_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [LVL_W-1:0]  MAX_LVL = {LVL_W{1'b1}};
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(STEP_CYCLES - 1);

  state_e           state_q;
  logic [PS_W-1:0]  presc_q;
  logic [LVL_W-1:0] tgt_shade_q, tgt_shade_d;
  logic [CNT_W-1:0] tgt_light_q, tgt_light_d;
  logic             err_q;

  logic             tc_ok;
  logic             dim;
  logic [CNT_W-1:0] len_c;
  logic             shade_at, light_at;
  logic             step;

  // Target derivation from the command fields (only used at acceptance).
  always_comb begin
    tc_ok       = 1'b1;
    tgt_shade_d = '0;
    tgt_light_d = '0;
    len_c       = (32'(length) > NUM_LIGHTS) ? CNT_W'(NUM_LIGHTS) : length;
    dim         = (32'(ulight) < ULIGHT_TH);
    case (tcode)
      TC_OFF: ;
      TC_DAY: tgt_shade_d = MAX_LVL;
      TC_DUSK: begin
        tgt_shade_d = MAX_LVL >> 1;
        tgt_light_d = len_c >> 1;
      end
      TC_EVE: tgt_light_d = dim ? len_c : (len_c >> 1);
      TC_MAN: begin
        tgt_shade_d = ulight;
        tgt_light_d = dim ? len_c : '0;
      end
      default: tc_ok = 1'b0;
    endcase
  end

  // A step fires on prescaler terminal count only while still short of target.
  assign step = (state_q == RAMP) && !(shade_at && light_at) && (presc_q == PS_LAST);

  // Controller FSM, prescaler, target registers and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      tgt_shade_q <= '0;
      tgt_light_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (tc_ok) begin
              tgt_shade_q <= tgt_shade_d;
              tgt_light_q <= tgt_light_d;
              presc_q     <= '0;
              state_q     <= RAMP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (shade_at && light_at) begin
            state_q <= DONE;
          end else if (presc_q == PS_LAST) begin
            presc_q <= '0;
          end else begin
            presc_q <= presc_q + PS_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  ramp_step #(.W(LVL_W)) u_shade (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (step),
    .target_i    (tgt_shade_q),
    .value_o     (wshade),
    .at_target_o (shade_at)
  );

  ramp_step #(.W(CNT_W)) u_lights (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (step),
    .target_i    (tgt_light_q),
    .value_o     (lightnum),
    .at_target_o (light_at)
  );

  // Lamp enables decoded straight from the lamp-count register.
  always_comb begin
    lightstate = '0;
    for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
      lightstate[i] = therm_bit(i, 32'(lightnum));
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: doc/light_ramp_ctrl.md
# light_ramp_ctrl

Clocked, parametrised lighting controller for the home-system lighting path. It accepts a one-hot time-of-day command together with ambient light level and room length, and computes window-shade and lamp-count targets. It then ramps the shade position and the number of lit lamps one step at a time at a programmable rate, and reports completion. It replaces the purely combinational lighting stage, adding lamp-count scaling, gradual transitions, a valid/ready command handshake and error reporting.

## Interface
- NUM_LIGHTS, 16, number of lamps driven; CNT_W = $clog2(NUM_LIGHTS+1) is derived from it
- LVL_W, 4, width of light-level and shade values; MAX_LVL = 2^LVL_W-1
- STEP_CYCLES, 4, clock cycles per ramp step; must be ≥1
- ULIGHT_TH, 8, ambient-level threshold for the light rules below
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in IDLE
- tcode  in  4  one-hot time code, or 0000
- ulight  in  LVL_W  ambient light level
- length  in  CNT_W  room length in lamp units
- wshade  out  LVL_W  current shade opening, 0 = closed, MAX_LVL = open
- lightnum  out  CNT_W  current count of lit lamps
- lightstate  out  NUM_LIGHTS  thermometer code; bit i = (i < lightnum)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the ramp completes
- err  out  1  one-cycle pulse when an invalid tcode is accepted

## Operation
- A command is accepted at a clock edge where cmd_valid & cmd_ready. Inputs are sampled only at acceptance; cmd_valid is ignored while busy.
- len_c = min(length, NUM_LIGHTS).
- Targets by tcode:
  - 0000 OFF: shade 0, lights 0.
  - 0001 DAY: shade MAX_LVL, lights 0.
  - 0010 DUSK: shade MAX_LVL>>1, lights len_c>>1.
  - 0100 EVENING: shade 0; lights len_c if ulight < ULIGHT_TH, else len_c>>1.
  - 1000 MANUAL: shade = ulight; lights len_c if ulight < ULIGHT_TH, else 0.
  - Any other value: the command is consumed and err pulses for one cycle. Targets, outputs and state are unchanged; the FSM stays in IDLE.
- FSM states are IDLE, RAMP and DONE.
  - IDLE to RAMP on a valid accept. At that edge: load targets, clear the prescaler.
  - In RAMP, if wshade == shade target and lightnum == lights target at an edge, go to DONE. No step is taken.
  - Otherwise the prescaler counts 0..STEP_CYCLES-1. At terminal count it wraps to 0, and wshade and lightnum each move by ±1 toward their targets, independently and in the same cycle.
  - DONE to IDLE unconditionally. done = 1 throughout the DONE cycle.
- All arithmetic is unsigned. Steps never overshoot, and the counters never wrap.

## Timing
- Reset (async assert) forces: wshade 0, lightnum 0, lightstate 0, busy 0, done 0, err 0, state IDLE, targets 0, prescaler 0. cmd_ready = 1 out of reset.
- Reset asserted mid-ramp zeroes all outputs immediately. Deassertion returns the block to IDLE; no done is produced for the aborted command.
- Accept at edge E0, with k = max(|Δshade|, |Δlights|):
  - the j-th step lands at edge E0 + j·STEP_CYCLES;
  - DONE is entered at E0 + k·STEP_CYCLES + 1;
  - cmd_ready rises at E0 + k·STEP_CYCLES + 2.
- Zero-step command (k = 0): DONE is entered at E0+1 and ready returns at E0+2.
- err is registered: it is high for the cycle after the accept edge. cmd_ready stays high throughout.
- lightstate is combinationally decoded from the lightnum register, with no extra latency.

## Structure
- Package lighting_pkg holds:
  - tcode constants TC_OFF, TC_DAY, TC_DUSK, TC_EVE, TC_MAN;
  - the FSM state enum (IDLE, RAMP, DONE);
  - a thermometer-decode function.
- Sub-module ramp_step, parametrised by width, is instantiated twice (shade, lights). It provides a register that moves ±1 toward a target on a step strobe, plus an at_target flag.
- The top level holds the prescaler, target computation, FSM and handshake.

## Test plan
All scenarios use defaults (N=16, S=4, TH=8).
- Reset → all outputs 0, cmd_ready 1, busy 0.
- From reset, DAY → wshade ramps 0..15, one step every 4 cycles; lightnum stays 0; done at E0+61; ready at E0+62.
- Then EVENING, ulight=3, length=9 → wshade 15→0 and lightnum 0→9 in parallel; final lightstate 0x01FF; done at E0+61.
- EVENING, ulight=3, length=20 → lightnum clamps to 16, lightstate 0xFFFF. MANUAL, ulight=14, length=9 → wshade 14, lightnum 0.
- tcode 0011 with cmd_valid in IDLE → err high for one cycle; outputs unchanged; busy stays 0.
- New cmd_valid while busy is ignored. rst_n low mid-ramp → immediate zero outputs, no done pulse, cmd_ready 1 after release.
